swervolf_sevenseg_scan: RTL and testbench

- Consumes the core's GPIO output word downstream of the SweRVolf Nexys A7 top.
- Drives the board's 8-digit common-anode seven-segment display by time-multiplexing one digit at a time.
- Double-buffers the displayed value so software writes never tear mid-frame.
- Inserts a blanking gap between digits to suppress ghosting.

---
 rtl/swervolf_sevenseg_pkg.sv | 22 ++
 rtl/swervolf_sevenseg_scan_hex_decode.sv | 13 +
 rtl/swervolf_sevenseg_scan.sv | 146 ++++++++++++++
 tb/tb_swervolf_sevenseg_scan.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/swervolf_sevenseg_pkg.sv
// Shared constants for the SweRVolf seven-segment scanner.
//   NUM_DIGITS : digits on the board display
//   SEG_BLANK  : segment pattern with every segment off (active-low)
//   HEX_SEG    : hex nibble -> {g,f,e,d,c,b,a}, active-low
//   scan_state_t : per-slot phase, all anodes off (BLANK) or digit lit (DRIVE)
package swervolf_sevenseg_pkg;

   localparam int NUM_DIGITS = 8;

   localparam logic [6:0] SEG_BLANK = 7'h7F;

   localparam logic [6:0] HEX_SEG [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

   typedef enum logic {
      ST_BLANK = 1'b0,
      ST_DRIVE = 1'b1
   } scan_state_t;

endpackage

// File: rtl/swervolf_sevenseg_scan_hex_decode.sv
// Combinational hex-to-seven-segment decoder.
//   i_nibble : hex digit 0..F
//   o_seg_n  : segments {g,f,e,d,c,b,a}, active-low
module sevenseg_hex_decode
   import swervolf_sevenseg_pkg::*;
(
   input  logic [3:0] i_nibble,
   output logic [6:0] o_seg_n
);

   assign o_seg_n = HEX_SEG[i_nibble];

endmodule

// File: rtl/swervolf_sevenseg_scan.sv
// Time-multiplexed driver for the 8-digit common-anode display.
// A write lands in a pending buffer; it is copied to the active buffer only
// at the start of digit 0's slot, so a frame never mixes old and new values.
// Each slot opens with a blanking gap (all anodes off) to suppress ghosting.
//   clk, rstn : clock, asynchronous active-low reset
//   i_we      : one-cycle strobe capturing i_data/i_dp/i_en into pending
//   i_data    : nibble k drives digit k
//   i_dp      : decimal point per digit, 1 = lit
//   i_en      : digit enable, 1 = shown
//   o_an_n    : anode selects, active-low
//   o_seg_n   : segments {g,f,e,d,c,b,a}, active-low
//   o_dp_n    : decimal point, active-low
//   o_frame   : one-cycle pulse marking the frame commit point
module swervolf_sevenseg_scan
   import swervolf_sevenseg_pkg::*;
#(
   parameter int SLOT_CYCLES  = 6250,
   parameter int BLANK_CYCLES = 64
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        i_we,
   input  logic [31:0] i_data,
   input  logic [7:0]  i_dp,
   input  logic [7:0]  i_en,
   output logic [7:0]  o_an_n,
   output logic [6:0]  o_seg_n,
   output logic        o_dp_n,
   output logic        o_frame
);

   localparam int CW = $clog2(SLOT_CYCLES);
   localparam int IW = $clog2(NUM_DIGITS);
   localparam logic [CW-1:0] COUNT_LAST = CW'(SLOT_CYCLES - 1);
   localparam logic [CW-1:0] BLANK_END  = CW'(BLANK_CYCLES);

   logic [31:0]   r_pend_data, r_act_data;
   logic [7:0]    r_pend_dp,   r_act_dp;
   logic [7:0]    r_pend_en,   r_act_en;
   logic          r_dirty;
   logic [CW-1:0] r_count;
   logic [IW-1:0] r_idx;
   scan_state_t   r_state;

   logic [CW-1:0] w_count_nxt;
   logic [IW-1:0] w_idx_nxt;
   scan_state_t   w_state_nxt;
   logic          w_commit;
   logic [3:0]    w_nibble;
   logic [6:0]    w_seg_dec;
   logic [7:0]    w_an_n;
   logic [6:0]    w_seg_n;
   logic          w_dp_n;

   // Digit index wraps 7 -> 0 through its natural 3-bit width.
   assign w_count_nxt = (r_count == COUNT_LAST) ? '0 : r_count + 1'b1;
   assign w_idx_nxt   = (r_count == COUNT_LAST) ? r_idx + 1'b1 : r_idx;
   assign w_commit    = (r_count == '0) && (r_idx == '0);
   assign w_nibble    = r_act_data[4*r_idx +: 4];

   sevenseg_hex_decode u_hex_decode (
      .i_nibble (w_nibble),
      .o_seg_n  (w_seg_dec)
   );

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_count <= '0;
         r_idx   <= '0;
         r_state <= ST_BLANK;
      end else begin
         r_count <= w_count_nxt;
         r_idx   <= w_idx_nxt;
         r_state <= w_state_nxt;
      end
   end

   // State tracks the count one step ahead, so r_state always matches r_count.
   always_comb begin
      // NOTE: every combinational output gets a default first; a missing
      // branch would otherwise infer a latch.
      w_state_nxt = (w_count_nxt < BLANK_END) ? ST_BLANK : ST_DRIVE;
      w_an_n      = 8'hFF;
      w_seg_n     = SEG_BLANK;
      w_dp_n      = 1'b1;
      if (r_state == ST_DRIVE) begin
         if (r_act_en[r_idx]) begin
            w_an_n[r_idx] = 1'b0;
         end
         w_seg_n = w_seg_dec;
         w_dp_n  = ~(r_act_dp[r_idx] & r_act_en[r_idx]);
      end
   end

   // A write in the commit cycle bypasses pending straight into active, so
   // dirty never survives a commit.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_pend_data <= '0;
         r_pend_dp   <= '0;
         r_pend_en   <= '0;
         r_act_data  <= '0;
         r_act_dp    <= '0;
         r_act_en    <= '0;
         r_dirty     <= 1'b0;
      end else begin
         if (i_we) begin
            r_pend_data <= i_data;
            r_pend_dp   <= i_dp;
            r_pend_en   <= i_en;
         end
         if (w_commit) begin
            if (i_we) begin
               r_act_data <= i_data;
               r_act_dp   <= i_dp;
               r_act_en   <= i_en;
            end else if (r_dirty) begin
               r_act_data <= r_pend_data;
               r_act_dp   <= r_pend_dp;
               r_act_en   <= r_pend_en;
            end
            r_dirty <= 1'b0;
         end else if (i_we) begin
            r_dirty <= 1'b1;
         end
      end
   end

   // Registered pins: glitch-free, one cycle behind the selecting state.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         o_an_n  <= 8'hFF;
         o_seg_n <= SEG_BLANK;
         o_dp_n  <= 1'b1;
         o_frame <= 1'b0;
      end else begin
         o_an_n  <= w_an_n;
         o_seg_n <= w_seg_n;
         o_dp_n  <= w_dp_n;
         o_frame <= w_commit;
      end
   end

endmodule

// File: tb/tb_swervolf_sevenseg_scan.sv
// Scoreboard bench: the stimulus pushes the expected contents of each frame;
// the monitor pops one entry on every o_frame pulse and checks blank and
// drive windows of all eight slots against a hand-coded decode table.
module tb_swervolf_sevenseg_scan;

   localparam int SLOT  = 16;
   localparam int BLANK = 4;
   localparam int FRAME = 8 * SLOT;

   localparam logic [6:0] SEG_TAB [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };
   localparam logic [15:0] BLANK_PINS = {8'hFF, 7'h7F, 1'b1};

   typedef struct packed {
      logic [31:0] data;
      logic [7:0]  dp;
      logic [7:0]  en;
   } frame_t;

   logic        clk = 1'b0;
   logic        rstn;
   logic        i_we;
   logic [31:0] i_data;
   logic [7:0]  i_dp;
   logic [7:0]  i_en;
   logic [7:0]  o_an_n;
   logic [6:0]  o_seg_n;
   logic        o_dp_n;
   logic        o_frame;

   frame_t exp_q[$];
   int     n_vec    = 0;
   int     n_miss   = 0;
   logic   mon_busy = 1'b0;

   always #5 clk = ~clk;

   swervolf_sevenseg_scan #(
      .SLOT_CYCLES  (SLOT),
      .BLANK_CYCLES (BLANK)
   ) dut (
      .clk     (clk),
      .rstn    (rstn),
      .i_we    (i_we),
      .i_data  (i_data),
      .i_dp    (i_dp),
      .i_en    (i_en),
      .o_an_n  (o_an_n),
      .o_seg_n (o_seg_n),
      .o_dp_n  (o_dp_n),
      .o_frame (o_frame)
   );

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] pins();
      return {o_an_n, o_seg_n, o_dp_n};
   endfunction

   function automatic logic [15:0] drive_exp(input frame_t f, input int k);
      logic [7:0] an;
      logic       dp_n;
      logic [3:0] nib;
      nib  = f.data[4*k +: 4];
      an   = 8'hFF;
      dp_n = 1'b1;
      if (f.en[k]) begin
         an[k] = 1'b0;
         dp_n  = ~f.dp[k];
      end
      return {an, SEG_TAB[nib], dp_n};
   endfunction

   task automatic go(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic write(input logic [31:0] d, input logic [7:0] dp, input logic [7:0] en);
      i_we   = 1'b1;
      i_data = d;
      i_dp   = dp;
      i_en   = en;
      @(negedge clk);
      i_we   = 1'b0;
   endtask

   task automatic push(input logic [31:0] d, input logic [7:0] dp, input logic [7:0] en);
      frame_t f;
      f.data = d;
      f.dp   = dp;
      f.en   = en;
      exp_q.push_back(f);
   endtask

   task automatic wait_frame(input string tag);
      for (int i = 0; i < FRAME + 8; i++) begin
         @(negedge clk);
         if (o_frame) return;
      end
      n_vec++;
      n_miss++;
      $display("FAIL wait_frame %s: o_frame absent, still 0 after %0d cycles", tag, FRAME + 8);
   endtask

   // Monitor: offset j counts negedges from the o_frame pulse.
   initial begin
      frame_t f;
      int     fid;
      int     k;
      int     c;
      fid = 0;
      forever begin
         @(negedge clk);
         if (rstn === 1'b1 && o_frame === 1'b1 && exp_q.size() > 0) begin
            f        = exp_q.pop_front();
            mon_busy = 1'b1;
            for (int j = 0; j < FRAME; j++) begin
               if (j > 0) @(negedge clk);
               k = j / SLOT;
               c = j % SLOT;
               if (j == 1)
                  check($sformatf("f%0d frame_width", fid), {15'd0, o_frame}, 16'd0);
               if (c == 0 || c == BLANK - 1)
                  check($sformatf("f%0d d%0d blank c%0d", fid, k, c), pins(), BLANK_PINS);
               if (c == BLANK || c == SLOT - 1)
                  check($sformatf("f%0d d%0d drive c%0d", fid, k, c), pins(), drive_exp(f, k));
            end
            mon_busy = 1'b0;
            fid++;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
      $fatal(1);
   end

   initial begin
      rstn   = 1'b0;
      i_we   = 1'b0;
      i_data = '0;
      i_dp   = '0;
      i_en   = '0;
      go(3);
      check("reset pins", pins(), BLANK_PINS);
      check("reset frame", {15'd0, o_frame}, 16'd0);

      // Frame 0: cleared buffers, nothing enabled.
      push(32'h0, 8'h00, 8'h00);
      rstn = 1'b1;
      @(negedge clk);
      check("frame after release", {15'd0, o_frame}, 16'd1);
      go(10);
      write(32'h76543210, 8'h00, 8'hFF);
      push(32'h76543210, 8'h00, 8'hFF);

      // Frame 1: scan order. Frame 2 expects the same value.
      wait_frame("f1");
      push(32'h76543210, 8'h00, 8'hFF);

      // Frame 2: write lands while digit 3 drives; this frame stays old.
      wait_frame("f2");
      go(56);
      write(32'h12345678, 8'h00, 8'hFF);
      push(32'h12345678, 8'h00, 8'hFF);

      // Frame 3: write in the commit cycle, bypassing straight to frame 4.
      wait_frame("f3");
      push(32'hAAAAAAAA, 8'h00, 8'hFF);
      go(127);
      write(32'hAAAAAAAA, 8'h00, 8'hFF);

      // Frame 4 (already at its pulse): load enables/decimal points.
      go(20);
      write(32'h89ABCDEF, 8'h05, 8'h0F);
      push(32'h89ABCDEF, 8'h05, 8'h0F);

      // Frame 5: two writes, last one wins.
      wait_frame("f5");
      go(10);
      write(32'h11111111, 8'h00, 8'hFF);
      go(30);
      write(32'h22222222, 8'h00, 8'hFF);
      push(32'h22222222, 8'h00, 8'hFF);

      // Frame 6 checked by the monitor; frame 7 hosts the reset test.
      wait_frame("f6");
      wait_frame("f7");
      go(56);
      check("pre-reset drive d3", pins(), {8'hF7, 7'h24, 1'b1});
      push(32'h0, 8'h00, 8'h00);
      rstn = 1'b0;
      #1;
      check("async reset pins", pins(), BLANK_PINS);
      check("async reset frame", {15'd0, o_frame}, 16'd0);
      go(3);
      rstn = 1'b1;
      @(negedge clk);
      check("frame after re-release", {15'd0, o_frame}, 16'd1);
      go(10);
      write(32'hFEDCBA98, 8'h80, 8'h81);
      push(32'hFEDCBA98, 8'h80, 8'h81);
      wait_frame("f1 after reset");

      begin : drain
         for (int i = 0; i < FRAME + 20; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !mon_busy) disable drain;
         end
         n_vec++;
         n_miss++;
         $display("FAIL drain: %0d frames still queued, expected 0", exp_q.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
